// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
//   Shared constants, state type and helper function for the reorder buffer
//   allocation / commit controller.
//
//   ROB_BANKS : lanes per row, one per storage bank
//   ROB_DEPTH : rows per bank
//   ROB_ROW_W : row index width
//   ROB_ID_W  : ROB id width, {wrap bit, row}
// ---------------------------------------------------------------------------
package rob_pkg;

  localparam int ROB_BANKS = 4;
  localparam int ROB_DEPTH = 128;
  localparam int ROB_ROW_W = 7;
  localparam int ROB_ID_W  = 8;

  // RUN is normal operation; FLUSH is the single cycle spent clearing the
  // ROB after an excepting lane reaches commit.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_state_e;

  // In-order prefix commit. Walking the banks from lane 0 upward, every
  // lane still pending at the head row (rem) commits only if it is ready,
  // has no exception, and nothing pending below it was held back. Lanes that
  // are not pending never block higher lanes.
  function automatic logic [ROB_BANKS-1:0] prefix_commit(
    input logic [ROB_BANKS-1:0] rem,
    input logic [ROB_BANKS-1:0] rdy,
    input logic [ROB_BANKS-1:0] exc
  );
    logic [ROB_BANKS-1:0] mask;
    logic                 blocked;
    mask    = '0;
    blocked = 1'b0;
    for (int i = 0; i < ROB_BANKS; i++) begin
      if (rem[i]) begin
        if (!blocked && rdy[i] && !exc[i]) begin
          mask[i] = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// ---------------------------------------------------------------------------
// rob_commit_sel
//   Purely combinational commit selector for the head row.
//
//   rem         : lanes of the head row still waiting to commit
//   rdy         : per-lane ready flags read at the head row
//   exc         : per-lane exception flags read at the head row
//   commit_mask : lanes that retire this cycle (in-order prefix)
//   exc_now     : oldest pending lane is ready and excepting
//   exc_bank    : bank index of the oldest pending lane
// ---------------------------------------------------------------------------
module rob_commit_sel
  import rob_pkg::*;
(
  input  logic [ROB_BANKS-1:0] rem,
  input  logic [ROB_BANKS-1:0] rdy,
  input  logic [ROB_BANKS-1:0] exc,
  output logic [ROB_BANKS-1:0] commit_mask,
  output logic                 exc_now,
  output logic [1:0]           exc_bank
);

  logic found;

  // The exception is only taken once it is the oldest pending lane, i.e.
  // every lane below it in the row has already retired. When that happens
  // nothing commits this cycle; the prefix function would already yield an
  // empty mask, the explicit gate just makes the intent obvious.
  always_comb begin
    exc_now  = 1'b0;
    exc_bank = '0;
    found    = 1'b0;
    for (int i = 0; i < ROB_BANKS; i++) begin
      if (rem[i] && !found) begin
        found    = 1'b1;
        exc_bank = 2'(i);
        exc_now  = rdy[i] & exc[i];
      end
    end
    commit_mask = exc_now ? '0 : prefix_commit(rem, rdy, exc);
  end

endmodule

// File: rtl/rob_alloc_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rob_alloc_commit_ctrl
//   Head/tail pointer and sequencing controller for the 4-bank ROB storage.
//   Grants one dispatch row per cycle, retires the head row lane by lane in
//   ascending bank order, and turns an excepting lane at the head into a
//   one-cycle flush that empties the ROB.
//
//   clk, rst     : clock, synchronous active-high reset
//   alloc_req    : dispatch group present
//   alloc_mask   : valid lanes of the dispatch group
//   alloc_gnt    : group accepted this cycle
//   alloc_row    : row written on grant (current tail)
//   alloc_id     : {tail wrap bit, tail}
//   head_row     : row presented to the storage read ports
//   head_valid   : valid field read at head_row
//   head_rdy     : rdy field read at head_row
//   head_exc     : exception field read at head_row
//   commit_mask  : lanes retiring this cycle (also clears their valid bits)
//   commit_row   : row being committed, same as head_row
//   exc_valid    : excepting lane reached commit (one-cycle pulse)
//   exc_bank     : bank of the excepting lane
//   exc_row      : row of the excepting lane
//   flush        : ROB flush pulse
//   count        : occupied rows
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module rob_alloc_commit_ctrl
  import rob_pkg::*;
#(
  parameter int BANKS = ROB_BANKS,
  parameter int DEPTH = ROB_DEPTH,
  parameter int ROW_W = ROB_ROW_W,
  parameter int ID_W  = ROB_ID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  input  logic [BANKS-1:0] alloc_mask,
  output logic             alloc_gnt,
  output logic [ROW_W-1:0] alloc_row,
  output logic [ID_W-1:0]  alloc_id,
  output logic [ROW_W-1:0] head_row,
  input  logic [BANKS-1:0] head_valid,
  input  logic [BANKS-1:0] head_rdy,
  input  logic [BANKS-1:0] head_exc,
  output logic [BANKS-1:0] commit_mask,
  output logic [ROW_W-1:0] commit_row,
  output logic             exc_valid,
  output logic [1:0]       exc_bank,
  output logic [ROW_W-1:0] exc_row,
  output logic             flush,
  output logic [ROW_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = ROW_W + 1;

  rob_state_e       state_q, state_d;
  logic [ROW_W-1:0] head_q, head_d;
  logic [ROW_W-1:0] tail_q, tail_d;
  logic             head_wrap_q, head_wrap_d;
  logic             tail_wrap_q, tail_wrap_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BANKS-1:0] done_mask_q, done_mask_d;

  logic [BANKS-1:0] rem;
  logic [BANKS-1:0] sel_mask;
  logic             sel_exc;
  logic [1:0]       sel_bank;
  logic             is_full;
  logic             is_empty;
  logic             active;
  logic             exc_now;
  logic             retire;
  logic             gnt;

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  // Lanes of the head row that are valid but were not retired in an
  // earlier cycle of a partially committed row.
  assign rem = head_valid & ~done_mask_q;

  rob_commit_sel u_commit_sel (
    .rem         (rem),
    .rdy         (head_rdy),
    .exc         (head_exc),
    .commit_mask (sel_mask),
    .exc_now     (sel_exc),
    .exc_bank    (sel_bank)
  );

  // Commit decisions are only meaningful while running with something at
  // the head; otherwise the head_* inputs are ignored entirely.
  always_comb begin
    active  = ~rst & (state_q == RUN) & ~is_empty;
    exc_now = active & sel_exc;
    retire  = active & ~sel_exc & ((rem & ~sel_mask) == '0);
    gnt     = ~rst & alloc_req & (|alloc_mask) & ~is_full
            & (state_q == RUN) & ~exc_now;
  end

  // Next-state logic. A flush cycle returns every pointer to zero no matter
  // what else is requested. Grant and retire are independent so the tail
  // and head can both move in one cycle, leaving the count unchanged.
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    head_wrap_d = head_wrap_q;
    tail_wrap_d = tail_wrap_q;
    count_d     = count_q;
    done_mask_d = done_mask_q;

    if (state_q == FLUSH) begin
      state_d     = RUN;
      head_d      = '0;
      tail_d      = '0;
      head_wrap_d = 1'b0;
      tail_wrap_d = 1'b0;
      count_d     = '0;
      done_mask_d = '0;
    end else begin
      if (gnt) begin
        tail_d = tail_q + ROW_W'(1);
        if (tail_q == ROW_W'(DEPTH - 1)) begin
          tail_wrap_d = ~tail_wrap_q;
        end
      end

      if (retire) begin
        head_d      = head_q + ROW_W'(1);
        done_mask_d = '0;
        if (head_q == ROW_W'(DEPTH - 1)) begin
          head_wrap_d = ~head_wrap_q;
        end
      end else if (active) begin
        done_mask_d = done_mask_q | sel_mask;
      end

      if (gnt && !retire) begin
        count_d = count_q + CNT_W'(1);
      end else if (retire && !gnt) begin
        count_d = count_q - CNT_W'(1);
      end

      if (exc_now) begin
        state_d = FLUSH;
      end
    end
  end

  // State register with synchronous reset; reset also abandons a flush or
  // a partially committed row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      head_q      <= '0;
      tail_q      <= '0;
      head_wrap_q <= 1'b0;
      tail_wrap_q <= 1'b0;
      count_q     <= '0;
      done_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_wrap_q <= head_wrap_d;
      tail_wrap_q <= tail_wrap_d;
      count_q     <= count_d;
      done_mask_q <= done_mask_d;
    end
  end

  // Output drive. Exception fields are held at zero outside the pulse so
  // downstream logic never sees stale bank/row values.
  always_comb begin
    alloc_gnt   = gnt;
    alloc_row   = tail_q;
    alloc_id    = {tail_wrap_q, tail_q};
    head_row    = head_q;
    commit_row  = head_q;
    commit_mask = (active & ~sel_exc) ? sel_mask : '0;
    exc_valid   = exc_now;
    exc_bank    = exc_now ? sel_bank : 2'd0;
    exc_row     = exc_now ? head_q : '0;
    flush       = ~rst & (state_q == FLUSH);
    count       = count_q;
    full        = is_full;
    empty       = is_empty;
  end

endmodule
